// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared types and constants for the instruction sequencer
package instr_seq_pkg;

    // Sequencer FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    // Instruction word that stops the sequencer after it executes
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    // Instruction field slices
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int JTARGET_MSB = 25;
    localparam int IMM_MSB     = 15;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction memory fetch bus between sequencer and imem
interface instr_sequencer_if #(
    parameter int ADDR_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/instr_sequencer_pc_next_calc.sv
// rtl/instr_sequencer_pc_next_calc.sv - combinational next-PC selection for jump/branch/sequential flow
module pc_next_calc
    import instr_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [31:0]       i_instr,
    input  logic              i_jump,
    input  logic              i_branch,
    input  logic              i_zero,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_pc;
    logic [ADDR_W-1:0] w_jump_pc;
    logic              w_unused_opcode;

    // Opcode is decoded outside; only the low fields steer the PC
    assign w_unused_opcode = ^i_instr[OPCODE_MSB:OPCODE_LSB];

    assign w_pc4    = i_pc + ADDR_W'(4);
    assign w_br_off = {{(ADDR_W-18){i_instr[IMM_MSB]}}, i_instr[IMM_MSB:0], 2'b00};
    assign w_br_pc  = w_pc4 + w_br_off;

    // Jump keeps the region bits of pc+4 above the 28-bit target window
    if (ADDR_W > 28) begin : g_jump_region
        assign w_jump_pc = {w_pc4[ADDR_W-1:28], i_instr[JTARGET_MSB:0], 2'b00};
    end else begin : g_jump_flat
        assign w_jump_pc = {i_instr[JTARGET_MSB:0], 2'b00};
    end

    // Jump beats a taken branch, which beats sequential flow
    always_comb begin
        o_next_pc = w_pc4;
        if (i_jump) begin
            o_next_pc = w_jump_pc;
        end else if (i_branch && i_zero) begin
            o_next_pc = w_br_pc;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute controller in front of a single-cycle execute unit
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT    = 16,
    parameter logic [31:0]     HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    instr_sequencer_if.master imem,
    input  logic              i_start,
    input  logic              i_halt_req,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic              i_zero,
    output logic [31:0]       o_instr,
    output logic              o_exec_en,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_fetch_err,
    output logic [15:0]       o_retired
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [7:0]        r_wait_cnt;
    logic              r_fetch_err;
    logic [15:0]       r_retired;

    logic              w_start_run;
    logic              w_load_instr;
    logic              w_fetch_timeout;
    logic              w_retire;
    logic [ADDR_W-1:0] w_next_pc;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .i_pc      (r_pc),
        .i_instr   (r_instr),
        .i_jump    (i_jump),
        .i_branch  (i_branch),
        .i_zero    (i_zero),
        .o_next_pc (w_next_pc)
    );

    // Next-state and one-cycle control strobes; imem_valid only matters in FETCH
    always_comb begin
        w_state_next    = r_state;
        w_start_run     = 1'b0;
        w_load_instr    = 1'b0;
        w_fetch_timeout = 1'b0;
        w_retire        = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (i_start) begin
                    w_start_run  = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem.imem_valid) begin
                    w_load_instr = 1'b1;
                    w_state_next = ST_EXEC;
                end else if (i_halt_req) begin
                    w_state_next = ST_HALT;
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_fetch_timeout = 1'b1;
                    w_state_next    = ST_HALT;
                end
            end
            ST_EXEC: begin
                w_retire = 1'b1;
                if ((r_instr == HALT_INSTR) || i_halt_req) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch wait counter: counts only while the fetch is still outstanding
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_FETCH) && (w_state_next == ST_FETCH)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // PC: reloaded on start, advanced at the end of each EXEC cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_start_run) begin
            r_pc <= RESET_PC;
        end else if (w_retire) begin
            r_pc <= w_next_pc;
        end
    end

    // Instruction register: captured on the accepted fetch response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr <= '0;
        end else if (w_load_instr) begin
            r_instr <= imem.imem_rdata;
        end
    end

    // Sticky fetch error: set on timeout, cleared only by a new start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_err <= 1'b0;
        end else if (w_start_run) begin
            r_fetch_err <= 1'b0;
        end else if (w_fetch_timeout) begin
            r_fetch_err <= 1'b1;
        end
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign imem.imem_req  = (r_state == ST_FETCH);
    assign imem.imem_addr = r_pc;

    assign o_instr     = r_instr;
    assign o_exec_en   = (r_state == ST_EXEC);
    assign o_pc        = r_pc;
    assign o_busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign o_halted    = (r_state == ST_HALT);
    assign o_fetch_err = r_fetch_err;
    assign o_retired   = r_retired;

endmodule
